// File: rtl/tnn_pkg.sv
// Shared definitions for the ternary popcount neuron: ternary output encoding,
// FSM state type and a constant-evaluable ceil(log2) helper.
package tnn_pkg;

    localparam logic [1:0] TERN_POS  = 2'b01;
    localparam logic [1:0] TERN_NEG  = 2'b11;
    localparam logic [1:0] TERN_ZERO = 2'b00;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Bits needed to index n distinct values; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/popcount_param.sv
// Combinational W-bit popcount. Defining APPROX_POPCOUNT_EN switches to a cheaper
// form that counts 5-bit groups and saturates each group at 3.
module popcount_param
    import tnn_pkg::*;
#(
    parameter int W = 10,
    localparam int CNT_W = clog2(W + 1)
) (
    input  logic [W-1:0]     bits,
    output logic [CNT_W-1:0] count
);

`ifdef APPROX_POPCOUNT_EN
    localparam int GRP  = 5;
    localparam int NGRP = (W + GRP - 1) / GRP;

    always_comb begin : approx_count
        int grp_cnt [NGRP];
        int total;
        total = 0;
        for (int g = 0; g < NGRP; g++) begin
            grp_cnt[g] = 0;
        end
        for (int i = 0; i < W; i++) begin
            grp_cnt[i / GRP] = grp_cnt[i / GRP] + int'(bits[i]);
        end
        // A group reports at most 3, so each group needs only a 2-bit adder.
        for (int g = 0; g < NGRP; g++) begin
            total = total + ((grp_cnt[g] > 3) ? 3 : grp_cnt[g]);
        end
        count = CNT_W'(total);
    end
`else
    always_comb begin : exact_count
        int total;
        total = 0;
        for (int i = 0; i < W; i++) begin
            total = total + int'(bits[i]);
        end
        count = CNT_W'(total);
    end
`endif

endmodule

// File: rtl/tnn_popcount_neuron.sv
// Multi-beat ternary neuron: accumulates +/- weighted popcounts over BEATS beats,
// thresholds P-N into a ternary result. APPROX_POPCOUNT_EN selects approximate popcount.
module tnn_popcount_neuron
    import tnn_pkg::*;
#(
    parameter int W     = 10,
    parameter int BEATS = 4,
    localparam int CNT_W = clog2(W + 1),
    localparam int ACC_W = clog2(W * BEATS + 1),
    localparam int SUM_W = ACC_W + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_x,
    input  logic [W-1:0]            in_wpos,
    input  logic [W-1:0]            in_wneg,
    input  logic signed [SUM_W-1:0] thr_pos,
    input  logic signed [SUM_W-1:0] thr_neg,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              out_y,
    output logic signed [SUM_W-1:0] out_sum,
    output logic                    dbg_state
);

    // Handshake: a beat transfers on a rising edge with in_valid && in_ready (and no
    // flush); a result transfers with out_valid && out_ready. Both readies/valids are
    // pure decodes of the state register.

    localparam int BCNT_W = (BEATS > 1) ? clog2(BEATS) : 1;
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [BCNT_W-1:0]         r_bcnt;
    logic [ACC_W-1:0]          r_p;
    logic [ACC_W-1:0]          r_n;
    logic signed [SUM_W-1:0]   r_thr_pos;
    logic signed [SUM_W-1:0]   r_thr_neg;
    logic [1:0]                r_out_y;
    logic signed [SUM_W-1:0]   r_out_sum;

    logic [W-1:0]              w_pos_bits;
    logic [W-1:0]              w_neg_bits;
    logic [CNT_W-1:0]          w_pos_cnt;
    logic [CNT_W-1:0]          w_neg_cnt;
    logic [ACC_W-1:0]          w_p_next;
    logic [ACC_W-1:0]          w_n_next;
    logic signed [SUM_W-1:0]   w_sum;
    logic signed [SUM_W-1:0]   w_thr_pos;
    logic signed [SUM_W-1:0]   w_thr_neg;
    logic [1:0]                w_y;
    logic                      w_accept;
    logic                      w_first;
    logic                      w_last;

    // A bit carrying both weights cancels to zero.
    assign w_pos_bits = in_x & in_wpos & ~in_wneg;
    assign w_neg_bits = in_x & in_wneg & ~in_wpos;

    popcount_param #(.W(W)) u_pop_pos (
        .bits  (w_pos_bits),
        .count (w_pos_cnt)
    );

    popcount_param #(.W(W)) u_pop_neg (
        .bits  (w_neg_bits),
        .count (w_neg_cnt)
    );

    assign w_accept = in_valid && (r_state == ACC) && !flush;
    assign w_first  = (r_bcnt == '0);
    assign w_last   = (r_bcnt == LAST_BEAT);

    assign w_p_next = r_p + ACC_W'(w_pos_cnt);
    assign w_n_next = r_n + ACC_W'(w_neg_cnt);
    assign w_sum    = $signed({1'b0, w_p_next}) - $signed({1'b0, w_n_next});

    // On the first beat the live thresholds apply, so BEATS=1 still sees them.
    assign w_thr_pos = w_first ? thr_pos : r_thr_pos;
    assign w_thr_neg = w_first ? thr_neg : r_thr_neg;

    assign w_y = (w_sum >= w_thr_pos) ? TERN_POS :
                 (w_sum <= w_thr_neg) ? TERN_NEG : TERN_ZERO;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACC:     if (w_accept && w_last) w_state_next = HOLD;
            HOLD:    if (out_ready) w_state_next = ACC;
            default: w_state_next = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt    <= '0;
            r_p       <= '0;
            r_n       <= '0;
            r_thr_pos <= '0;
            r_thr_neg <= '0;
            r_out_y   <= TERN_ZERO;
            r_out_sum <= '0;
        end else if (r_state == ACC) begin
            if (flush) begin
                r_bcnt <= '0;
                r_p    <= '0;
                r_n    <= '0;
            end else if (in_valid) begin
                if (w_first) begin
                    r_thr_pos <= thr_pos;
                    r_thr_neg <= thr_neg;
                end
                if (w_last) begin
                    r_bcnt    <= '0;
                    r_p       <= '0;
                    r_n       <= '0;
                    r_out_y   <= w_y;
                    r_out_sum <= w_sum;
                end else begin
                    r_bcnt <= r_bcnt + BCNT_W'(1);
                    r_p    <= w_p_next;
                    r_n    <= w_n_next;
                end
            end
        end
    end

    assign in_ready  = (r_state == ACC);
    assign out_valid = (r_state == HOLD);
    assign out_y     = r_out_y;
    assign out_sum   = r_out_sum;
    assign dbg_state = (r_state == HOLD);

endmodule

// File: tb/tb_tnn_popcount_neuron.sv
// Self-checking bench for tnn_popcount_neuron: directed cases with literal results,
// then randomized traffic checked every cycle against a behavioural model.
module tb_tnn_popcount_neuron;

    localparam int W     = 10;
    localparam int BEATS = 4;
    localparam int SUM_W = 7;
`ifdef APPROX_POPCOUNT_EN
    localparam int ONES     = 6;
    localparam int LOW_NIB  = 3;
`else
    localparam int ONES     = 10;
    localparam int LOW_NIB  = 4;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    flush = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [W-1:0]            in_x = '0;
    logic [W-1:0]            in_wpos = '0;
    logic [W-1:0]            in_wneg = '0;
    logic signed [SUM_W-1:0] thr_pos = '0;
    logic signed [SUM_W-1:0] thr_neg = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [1:0]              out_y;
    logic signed [SUM_W-1:0] out_sum;
    logic                    dbg_state;

    int checks = 0;
    int errors = 0;

    tnn_popcount_neuron #(.W(W), .BEATS(BEATS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_wpos   (in_wpos),
        .in_wneg   (in_wneg),
        .thr_pos   (thr_pos),
        .thr_neg   (thr_neg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_sum   (out_sum),
        .dbg_state (dbg_state)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference popcount written directly from the weighting rules.
    function automatic int popc(input logic [W-1:0] v);
        int total;
        int c;
        total = 0;
`ifdef APPROX_POPCOUNT_EN
        for (int g = 0; g < W; g += 5) begin
            c = 0;
            for (int b = g; b < g + 5 && b < W; b++) c = c + int'(v[b]);
            total = total + ((c > 3) ? 3 : c);
        end
`else
        c = 0;
        for (int i = 0; i < W; i++) total = total + int'(v[i]);
`endif
        return total;
    endfunction

    // Behavioural model: exp_q holds the pending result {y, sum}; non-empty means
    // the neuron is waiting for out_ready.
    logic [SUM_W+1:0] exp_q[$];
    int         m_p = 0, m_n = 0, m_beats = 0, m_tp = 0, m_tn = 0;
    int         last_sum = 0;
    logic [1:0] last_y = 2'b00;

    always @(posedge clk or negedge rst_n) begin : model
        int p, n, s, tp, tn;
        logic [1:0] y;
        if (!rst_n) begin
            m_p <= 0; m_n <= 0; m_beats <= 0; m_tp <= 0; m_tn <= 0;
            last_sum <= 0; last_y <= 2'b00;
            exp_q.delete();
        end else if (exp_q.size() != 0) begin
            if (out_ready) void'(exp_q.pop_front());
        end else if (flush) begin
            m_p <= 0; m_n <= 0; m_beats <= 0;
        end else if (in_valid) begin
            tp = (m_beats == 0) ? int'(thr_pos) : m_tp;
            tn = (m_beats == 0) ? int'(thr_neg) : m_tn;
            p  = m_p + popc(in_x & in_wpos & ~in_wneg);
            n  = m_n + popc(in_x & in_wneg & ~in_wpos);
            if (m_beats == BEATS - 1) begin
                s = p - n;
                y = (s >= tp) ? 2'b01 : (s <= tn) ? 2'b11 : 2'b00;
                exp_q.push_back({y, 7'(s)});
                last_sum <= s; last_y <= y;
                m_p <= 0; m_n <= 0; m_beats <= 0;
            end else begin
                m_p <= p; m_n <= n; m_beats <= m_beats + 1;
                m_tp <= tp; m_tn <= tn;
            end
        end
    end

    // Scoreboard compare, every cycle
    always @(negedge clk) begin
        check("in_ready",  int'(in_ready),  int'(exp_q.size() == 0));
        check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
        check("out_sum",   int'(out_sum),   last_sum);
        check("out_y",     int'(out_y),     int'(last_y));
    end

    // Driver tasks (called on a falling edge, return on a falling edge)
    task automatic send_beat(input logic [W-1:0] x, input logic [W-1:0] wp,
                             input logic [W-1:0] wn, input int tp, input int tn);
        int n;
        n = 0;
        in_x = x; in_wpos = wp; in_wneg = wn;
        thr_pos = 7'(tp); thr_neg = 7'(tn);
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("beat_accept_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_neuron(input logic [W-1:0] x, input logic [W-1:0] wp,
                               input logic [W-1:0] wn, input int tp, input int tn);
        for (int b = 0; b < BEATS; b++) send_beat(x, wp, wn, tp, tn);
    endtask

    task automatic expect_result(input string name, input int sum, input int y);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, int'(out_valid), 1);
        check({name, "_sum"},   int'(out_sum),   sum);
        check({name, "_y"},     int'(out_y),     y);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  int'(in_ready),  1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_y",     int'(out_y),     0);
        check("rst_out_sum",   int'(out_sum),   0);
        rst_n = 1'b1;
        @(negedge clk);

        // All-ones positive; later beats carry thresholds that must be ignored.
        send_beat(10'h3FF, 10'h3FF, 10'h000, 5, -5);
        for (int b = 1; b < BEATS; b++) send_beat(10'h3FF, 10'h3FF, 10'h000, 63, -64);
        check("t1_latency_valid", int'(out_valid), 1);
        check("t1_latency_ready", int'(in_ready),  0);
        expect_result("t1", 4 * ONES, 1);

        send_neuron(10'h3FF, 10'h3FF, 10'h3FF, 5, -5);
        expect_result("overlap", 0, 0);

        send_neuron(10'h3FF, 10'h001, 10'h00E, 5, -8);
        expect_result("neg_bound", -8, 3);
        send_neuron(10'h3FF, 10'h001, 10'h00E, -8, -8);
        expect_result("priority", -8, 1);

        send_neuron(10'h00F, 10'h3FF, 10'h000, 5, -5);
        expect_result("low_nibble", 4 * LOW_NIB, 1);

        // Flush after two beats, with a beat presented in the flush cycle.
        send_beat(10'h3FF, 10'h3FF, 10'h000, 5, -5);
        send_beat(10'h3FF, 10'h3FF, 10'h000, 5, -5);
        flush = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        send_neuron(10'h3FF, 10'h3FF, 10'h000, 5, -5);
        expect_result("flush", 4 * ONES, 1);

        // Asynchronous reset mid-neuron.
        send_beat(10'h3FF, 10'h3FF, 10'h000, 5, -5);
        send_beat(10'h3FF, 10'h3FF, 10'h000, 5, -5);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ready", int'(in_ready),  1);
        check("rst_mid_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_neuron(10'h3FF, 10'h3FF, 10'h000, 5, -5);
        expect_result("after_rst", 4 * ONES, 1);

        // Asynchronous reset while holding a result.
        send_neuron(10'h3FF, 10'h000, 10'h3FF, 5, -5);
        check("hold_before_rst", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_hold_valid", int'(out_valid), 0);
        check("rst_hold_sum",   int'(out_sum),   0);
        check("rst_hold_y",     int'(out_y),     0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-pressure: result held 5 cycles while a beat is offered.
        send_neuron(10'h0F0, 10'h0FF, 10'h300, 5, -5);
        in_x = 10'h3FF; in_wpos = 10'h3FF; in_wneg = 10'h000; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("stall_valid", int'(out_valid), 1);
            check("stall_sum",   int'(out_sum),   16);
            check("stall_y",     int'(out_y),     1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        expect_result("stall", 16, 1);
        send_neuron(10'h3FF, 10'h3FF, 10'h000, 5, -5);
        expect_result("post_stall", 4 * ONES, 1);

        // Randomized traffic, checked by the scoreboard.
        for (int c = 0; c < 4000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 30) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_x      = 10'($urandom_range(0, 1023));
            in_wpos   = 10'($urandom_range(0, 1023));
            in_wneg   = 10'($urandom_range(0, 1023));
            thr_pos   = 7'($urandom_range(0, 50) - 25);
            thr_neg   = 7'($urandom_range(0, 50) - 25);
            @(negedge clk);
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tnn_popcount_neuron.md
# tnn_popcount_neuron

Sequential ternary-neuron core that counts activations under a multi-beat fan-in. Each cycle it accepts one W-bit activation word with matching positive and negative weight masks. Over BEATS beats it accumulates the positive-weight popcount P and the negative-weight popcount N. It then compares P−N against two signed thresholds and emits a ternary output through a valid/ready handshake. It sits between the sensor/feature buffer and the next layer's input register in the printed TNN datapath.

## Interface
- W, 10: activation bits per beat (≥2)
- BEATS, 4: beats per neuron evaluation (≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous abort of the current neuron
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_x  in  W  binary activations
- in_wpos  in  W  positive-weight mask
- in_wneg  in  W  negative-weight mask
- thr_pos  in  SUM_W signed  +1 threshold, sampled on first beat
- thr_neg  in  SUM_W signed  −1 threshold, sampled on first beat
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_y  out  2  ternary result: 2'b01 = +1, 2'b11 = −1, 2'b00 = 0
- out_sum  out  SUM_W signed  P−N

Derived widths:
- CNT_W = clog2(W+1)
- ACC_W = clog2(W·BEATS+1)
- SUM_W = ACC_W+1

## Operation
- Per-beat masks:
  - pos_bits = in_x & in_wpos & ~in_wneg
  - neg_bits = in_x & in_wneg & ~in_wpos
  - A bit with both masks set counts as weight 0.
- Per beat: P += popcount(pos_bits) and N += popcount(neg_bits), each unsigned at ACC_W bits. No overflow by construction.
- States:
  - ACC: in_ready=1. Tracks beat counter bcnt from 0 to BEATS−1.
  - HOLD: in_ready=0, out_valid=1.
- ACC transitions:
  - Accepted beat with bcnt<BEATS−1: bcnt++ and stay in ACC.
  - Accepted beat with bcnt==BEATS−1: compute the result including that beat, register out_y and out_sum, clear P, N and bcnt, then go to HOLD.
- HOLD transitions: on out_ready, go to ACC. out_y and out_sum hold their values until the next result.
- Thresholds: thr_pos and thr_neg are latched on the beat where bcnt==0. Changes to them mid-neuron are ignored.
- Decision, with sum = P−N:
  - out_y = +1 if sum ≥ thr_pos.
  - Otherwise out_y = −1 if sum ≤ thr_neg.
  - Otherwise out_y = 0.
  - If the thresholds overlap, +1 has priority.
- flush in ACC: clears P, N and bcnt, and discards any beat presented in the same cycle.
- flush in HOLD: no effect; the pending result is still delivered.
- in_valid=0 cycles in ACC leave all state unchanged; a gap between beats is legal.

## Timing
- Reset values:
  - state=ACC, bcnt=0, P=N=0, latched thresholds=0
  - in_ready=1, out_valid=0, out_y=2'b00, out_sum=0
- Latency: out_valid rises in the cycle after the last beat is accepted.
- Throughput: one neuron per BEATS+1 cycles with back-to-back valid and immediate out_ready.
- in_ready is a registered state decode (state==ACC), with no combinational path from out_ready. The cycle after a handshake in HOLD accepts a beat.
- Reset asserted mid-neuron or in HOLD discards everything immediately and asynchronously. The first beat after reset release is bcnt=0.
- BEATS=1: every accepted beat produces a result.

## Configuration
- APPROX_POPCOUNT_EN defined:
  - Each per-beat popcount is computed over consecutive 5-bit groups; the last group may be shorter.
  - Each group count is saturated at 3, so a group with ≥4 set bits contributes 3.
  - Worst-case error is 2 per group per beat.
  - Purpose: a smaller printed-area adder tree.
- APPROX_POPCOUNT_EN undefined: exact popcount.
- Handshake, FSM and decision logic are identical in both builds.

## Structure
- Shared package tnn_pkg holds:
  - ternary encoding constants TERN_POS, TERN_NEG, TERN_ZERO
  - clog2 helper
  - state enum {ACC, HOLD}
- Sub-module popcount_param:
  - combinational, parameter W, input bits[W-1:0], output count[CNT_W-1:0]
  - contains the APPROX_POPCOUNT_EN group-saturation logic
  - instantiated twice, once for pos_bits and once for neg_bits

## Test plan
- Reset, exact build, W=10, BEATS=4: beats in_x=10'h3FF, wpos=10'h3FF, wneg=0, thr_pos=5, thr_neg=−5 -> out_sum=40, out_y=2'b01 one cycle after beat 4; in_ready=0 until out_ready.
- Overlap masks wpos=wneg=10'h3FF with all activations set, 4 beats -> out_sum=0, out_y=2'b00.
- Neg-heavy beats pos_bits=1 bit and neg_bits=3 bits, 4 beats, thr_neg=−8 -> out_sum=−8, out_y=2'b11 (≤ boundary); thr_pos=−8 instead -> out_y=2'b01 (priority).
- Two beats accepted, then flush, then 4 fresh all-ones positive beats -> out_sum=40. Additionally: rst_n low mid-neuron -> outputs return to reset values and the next neuron counts from beat 0.
- out_ready held low 5 cycles -> out_valid, out_y and out_sum stable; in_valid is ignored and no beats are lost.
- APPROX_POPCOUNT_EN, pos_bits=10'h3FF for one beat, BEATS=1 -> out_sum=6 (3+3); pos_bits=10'h00F -> out_sum=3.
